// File: rtl/ddr2_cmd_responder_if.sv
// DDR2 command bus as driven by the controller, plus the responder's
// per-bank status, error report and data-phase request outputs.
interface ddr2_cmd_responder_if;
   logic [3:0]  cmd;
   logic [2:0]  ba;
   logic [13:0] addr;
   logic [7:0]  bank_active;
   logic        cmd_err;
   logic [3:0]  err_code;
   logic [2:0]  err_bank;
   logic        rd_req_valid;
   logic [2:0]  rd_req_bank;
   logic [13:0] rd_req_row;
   logic [9:0]  rd_req_col;
   logic        wr_req_valid;
   logic [2:0]  wr_req_bank;
   logic [13:0] wr_req_row;
   logic [9:0]  wr_req_col;

   modport master (
      output cmd, ba, addr,
      input  bank_active, cmd_err, err_code, err_bank,
      input  rd_req_valid, rd_req_bank, rd_req_row, rd_req_col,
      input  wr_req_valid, wr_req_bank, wr_req_row, wr_req_col
   );

   modport slave (
      input  cmd, ba, addr,
      output bank_active, cmd_err, err_code, err_bank,
      output rd_req_valid, rd_req_bank, rd_req_row, rd_req_col,
      output wr_req_valid, wr_req_bank, wr_req_row, wr_req_col
   );
endinterface

// File: rtl/ddr2_cmd_responder.sv
// DDR2 device-side command decoder and protocol checker: per-bank state and
// timing counters, error reporting, and CL/CWL-delayed data-phase requests.
module ddr2_cmd_responder #(
   parameter int unsigned T_RCD = 15,
   parameter int unsigned T_RP  = 15,
   parameter int unsigned T_RAS = 40,
   parameter int unsigned T_RRD = 10,
   parameter int unsigned T_WR  = 15,
   parameter int unsigned T_WTR = 7,
   parameter int unsigned T_CCD = 2,
   parameter int unsigned T_RFC = 51,
   parameter int unsigned CL    = 5
) (
   input  logic                clk,
   input  logic                rst,
   ddr2_cmd_responder_if.slave bus
);
   localparam int unsigned CWL = CL - 1;

   localparam logic [7:0] RCD_LD = 8'(T_RCD - 1);
   localparam logic [7:0] RP_LD  = 8'(T_RP - 1);
   localparam logic [7:0] RAS_LD = 8'(T_RAS - 1);
   localparam logic [7:0] RRD_LD = 8'(T_RRD - 1);
   localparam logic [7:0] WR_LD  = 8'(T_WR - 1);
   localparam logic [7:0] WTR_LD = 8'(T_WTR - 1);
   localparam logic [7:0] CCD_LD = 8'(T_CCD - 1);
   localparam logic [7:0] RFC_LD = 8'(T_RFC - 1);

   typedef enum logic [1:0] {
      B_IDLE,
      B_ACTIVATING,
      B_ACTIVE,
      B_PRECHARGING
   } bank_state_e;

   typedef enum logic [3:0] {
      CMD_MRS = 4'b0000,
      CMD_REF = 4'b0001,
      CMD_PRE = 4'b0010,
      CMD_ACT = 4'b0011,
      CMD_WR  = 4'b0100,
      CMD_RD  = 4'b0101,
      CMD_NOP = 4'b0111
   } cmd_e;

   typedef struct packed {
      logic        valid;
      logic [2:0]  bank;
      logic [13:0] row;
      logic [9:0]  col;
   } req_t;

   function automatic logic [7:0] dec8(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

   bank_state_e st_q  [8];
   bank_state_e st_d  [8];
   logic [7:0]  tmr_q [8];
   logic [7:0]  tmr_d [8];
   logic [7:0]  ras_q [8];
   logic [7:0]  ras_d [8];
   logic [7:0]  twr_q [8];
   logic [7:0]  twr_d [8];
   logic [13:0] row_q [8];
   logic [13:0] row_d [8];

   logic [7:0] rrd_q, rrd_d;
   logic [7:0] ccd_q, ccd_d;
   logic [7:0] wtr_q, wtr_d;
   logic [7:0] rfc_q, rfc_d;

   req_t rd_pipe_q [CL];
   req_t rd_pipe_d [CL];
   req_t wr_pipe_q [CWL];
   req_t wr_pipe_d [CWL];

   logic [7:0] bank_active_q, bank_active_d;
   logic       cmd_err_q, cmd_err_d;
   logic [3:0] err_code_q, err_code_d;
   logic [2:0] err_bank_q, err_bank_d;

   logic       is_cmd, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, pre_all;
   logic [7:0] bank_open;
   logic       ras_hit, wr_hit, busy_any;
   logic [2:0] ras_bank, wr_bank, busy_bank;
   logic       rej, accept;
   logic [3:0] rej_code;
   logic [2:0] rej_bank;

   // Command decode and per-bank summaries used by the checker.
   always_comb begin
      is_cmd  = !bus.cmd[3] && (bus.cmd != CMD_NOP);
      is_act  = (bus.cmd == CMD_ACT);
      is_rd   = (bus.cmd == CMD_RD);
      is_wr   = (bus.cmd == CMD_WR);
      is_pre  = (bus.cmd == CMD_PRE);
      is_ref  = (bus.cmd == CMD_REF);
      is_mrs  = (bus.cmd == CMD_MRS);
      pre_all = bus.addr[10];
      for (int unsigned i = 0; i < 8; i++) begin
         bank_open[i] = (st_q[i] == B_ACTIVATING) || (st_q[i] == B_ACTIVE);
      end
      ras_hit   = 1'b0;
      wr_hit    = 1'b0;
      busy_any  = 1'b0;
      ras_bank  = '0;
      wr_bank   = '0;
      busy_bank = '0;
      // Scan from bank 7 downwards so the lowest offending bank is kept.
      for (int unsigned i = 0; i < 8; i++) begin
         if (bank_open[7 - i] && (ras_q[7 - i] != 8'd0)) begin
            ras_hit  = 1'b1;
            ras_bank = 3'(7 - i);
         end
         if (bank_open[7 - i] && (twr_q[7 - i] != 8'd0)) begin
            wr_hit  = 1'b1;
            wr_bank = 3'(7 - i);
         end
         if (st_q[7 - i] != B_IDLE) begin
            busy_any  = 1'b1;
            busy_bank = 3'(7 - i);
         end
      end
   end

   // Rule check; the if/else order encodes lowest-code-wins priority.
   always_comb begin
      rej      = 1'b0;
      rej_code = '0;
      rej_bank = bus.ba;
      if (is_cmd && (rfc_q != 8'd0)) begin
         rej = 1'b1; rej_code = 4'd1;
      end else if (is_act) begin
         if (st_q[bus.ba] != B_IDLE) begin
            rej = 1'b1; rej_code = 4'd2;
         end else if (rrd_q != 8'd0) begin
            rej = 1'b1; rej_code = 4'd3;
         end
      end else if (is_rd || is_wr) begin
         if (st_q[bus.ba] != B_ACTIVE) begin
            rej = 1'b1; rej_code = 4'd4;
         end else if (ccd_q != 8'd0) begin
            rej = 1'b1; rej_code = 4'd5;
         end else if (is_rd && (wtr_q != 8'd0)) begin
            rej = 1'b1; rej_code = 4'd6;
         end
      end else if (is_pre) begin
         if (pre_all) begin
            if (ras_hit) begin
               rej = 1'b1; rej_code = 4'd7; rej_bank = ras_bank;
            end else if (wr_hit) begin
               rej = 1'b1; rej_code = 4'd8; rej_bank = wr_bank;
            end
         end else if (bank_open[bus.ba]) begin
            if (ras_q[bus.ba] != 8'd0) begin
               rej = 1'b1; rej_code = 4'd7;
            end else if (twr_q[bus.ba] != 8'd0) begin
               rej = 1'b1; rej_code = 4'd8;
            end
         end
      end else if (is_ref || is_mrs) begin
         if (busy_any) begin
            rej = 1'b1; rej_code = 4'd9; rej_bank = busy_bank;
         end
      end
      accept = is_cmd && !rej;
   end

   // Next state: counters decay, banks settle, then the accepted command applies.
   always_comb begin
      rrd_d = dec8(rrd_q);
      ccd_d = dec8(ccd_q);
      wtr_d = dec8(wtr_q);
      rfc_d = dec8(rfc_q);
      for (int unsigned i = 0; i < 8; i++) begin
         tmr_d[i] = dec8(tmr_q[i]);
         ras_d[i] = dec8(ras_q[i]);
         twr_d[i] = dec8(twr_q[i]);
         row_d[i] = row_q[i];
         st_d[i]  = st_q[i];
         if ((st_q[i] == B_ACTIVATING) && (tmr_d[i] == 8'd0)) st_d[i] = B_ACTIVE;
         if ((st_q[i] == B_PRECHARGING) && (tmr_d[i] == 8'd0)) st_d[i] = B_IDLE;
      end
      if (accept) begin
         if (is_act) begin
            st_d[bus.ba]  = (RCD_LD == 8'd0) ? B_ACTIVE : B_ACTIVATING;
            tmr_d[bus.ba] = RCD_LD;
            ras_d[bus.ba] = RAS_LD;
            row_d[bus.ba] = bus.addr;
            rrd_d         = RRD_LD;
         end
         if (is_pre) begin
            for (int unsigned i = 0; i < 8; i++) begin
               if (bank_open[i] && (pre_all || (bus.ba == 3'(i)))) begin
                  st_d[i]  = (RP_LD == 8'd0) ? B_IDLE : B_PRECHARGING;
                  tmr_d[i] = RP_LD;
               end
            end
         end
         if (is_rd || is_wr) ccd_d = CCD_LD;
         if (is_wr) begin
            wtr_d         = WTR_LD;
            twr_d[bus.ba] = WR_LD;
         end
         if (is_ref) rfc_d = RFC_LD;
      end

      rd_pipe_d[0] = '0;
      if (accept && is_rd) begin
         rd_pipe_d[0].valid = 1'b1;
         rd_pipe_d[0].bank  = bus.ba;
         rd_pipe_d[0].row   = row_q[bus.ba];
         rd_pipe_d[0].col   = bus.addr[9:0];
      end
      for (int unsigned i = 1; i < CL; i++) rd_pipe_d[i] = rd_pipe_q[i - 1];

      wr_pipe_d[0] = '0;
      if (accept && is_wr) begin
         wr_pipe_d[0].valid = 1'b1;
         wr_pipe_d[0].bank  = bus.ba;
         wr_pipe_d[0].row   = row_q[bus.ba];
         wr_pipe_d[0].col   = bus.addr[9:0];
      end
      for (int unsigned i = 1; i < CWL; i++) wr_pipe_d[i] = wr_pipe_q[i - 1];
   end

   // Registered status outputs.
   always_comb begin
      cmd_err_d  = rej;
      err_code_d = rej_code;
      err_bank_d = rej ? rej_bank : 3'd0;
      for (int unsigned i = 0; i < 8; i++) begin
         bank_active_d[i] = (st_d[i] == B_ACTIVE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) begin
            st_q[i]  <= B_IDLE;
            tmr_q[i] <= '0;
            ras_q[i] <= '0;
            twr_q[i] <= '0;
            row_q[i] <= '0;
         end
         for (int unsigned i = 0; i < CL; i++) rd_pipe_q[i] <= '0;
         for (int unsigned i = 0; i < CWL; i++) wr_pipe_q[i] <= '0;
         rrd_q         <= '0;
         ccd_q         <= '0;
         wtr_q         <= '0;
         rfc_q         <= '0;
         bank_active_q <= '0;
         cmd_err_q     <= 1'b0;
         err_code_q    <= '0;
         err_bank_q    <= '0;
      end else begin
         st_q          <= st_d;
         tmr_q         <= tmr_d;
         ras_q         <= ras_d;
         twr_q         <= twr_d;
         row_q         <= row_d;
         rd_pipe_q     <= rd_pipe_d;
         wr_pipe_q     <= wr_pipe_d;
         rrd_q         <= rrd_d;
         ccd_q         <= ccd_d;
         wtr_q         <= wtr_d;
         rfc_q         <= rfc_d;
         bank_active_q <= bank_active_d;
         cmd_err_q     <= cmd_err_d;
         err_code_q    <= err_code_d;
         err_bank_q    <= err_bank_d;
      end
   end

   assign bus.bank_active  = bank_active_q;
   assign bus.cmd_err      = cmd_err_q;
   assign bus.err_code     = err_code_q;
   assign bus.err_bank     = err_bank_q;
   assign bus.rd_req_valid = rd_pipe_q[CL - 1].valid;
   assign bus.rd_req_bank  = rd_pipe_q[CL - 1].bank;
   assign bus.rd_req_row   = rd_pipe_q[CL - 1].row;
   assign bus.rd_req_col   = rd_pipe_q[CL - 1].col;
   assign bus.wr_req_valid = wr_pipe_q[CWL - 1].valid;
   assign bus.wr_req_bank  = wr_pipe_q[CWL - 1].bank;
   assign bus.wr_req_row   = wr_pipe_q[CWL - 1].row;
   assign bus.wr_req_col   = wr_pipe_q[CWL - 1].col;
endmodule
